// File: rtl/min_os_tx_scheduler.sv
// Round-robin transmit scheduler: arbitrates CHANNEL_COUNT producers onto one typed
// TX chunker handshake, acknowledges the granted channel and recovers from stalls.
module min_os_tx_scheduler #(
  parameter int CHANNEL_COUNT       = 4,
  parameter int MAX_CHUNK_BYTE_SIZE = 8,
  parameter int CHUNK_INDEX_SIZE    = 32,
  parameter int TIMEOUT_CYCLES      = 1000000
) (
  input  logic                                            CLK,
  input  logic                                            reset,
  input  logic [CHANNEL_COUNT-1:0]                        channel_enable,
  input  logic [CHANNEL_COUNT-1:0]                        channel_should_update,
  input  logic [8*CHANNEL_COUNT-1:0]                      channel_chunk_type,
  input  logic [8*MAX_CHUNK_BYTE_SIZE*CHANNEL_COUNT-1:0]  channel_chunk_bytes,
  input  logic [CHUNK_INDEX_SIZE*CHANNEL_COUNT-1:0]       channel_chunk_byte_size,
  output logic [CHANNEL_COUNT-1:0]                        channel_reset,
  output logic                                            tx_is_chunk_ready,
  output logic [7:0]                                      tx_chunk_type,
  output logic [8*MAX_CHUNK_BYTE_SIZE-1:0]                tx_chunk_bytes,
  output logic [CHUNK_INDEX_SIZE-1:0]                     tx_chunk_byte_size,
  input  logic                                            tx_is_chunker_done,
  output logic                                            busy,
  output logic [7:0]                                      active_channel,
  output logic [15:0]                                     timeout_count
);

  localparam int BYTES_W = 8 * MAX_CHUNK_BYTE_SIZE;
  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CHUNK_INDEX_SIZE-1:0] MAX_SIZE = CHUNK_INDEX_SIZE'(MAX_CHUNK_BYTE_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_STOP  = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  function automatic logic [7:0] wrap_index(input logic [7:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= CHANNEL_COUNT) sum = sum - CHANNEL_COUNT;
    return 8'(sum);
  endfunction

  function automatic logic [CHUNK_INDEX_SIZE-1:0] clamp_size(
    input logic [CHUNK_INDEX_SIZE-1:0] sz
  );
    return (sz > MAX_SIZE) ? MAX_SIZE : sz;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                       state_q;
  logic [7:0]                   grant_q;
  logic [7:0]                   ptr_q;
  logic [7:0]                   active_q;
  logic [CNT_W-1:0]             wait_cnt_q;
  logic [CHANNEL_COUNT-1:0]     chan_reset_q;
  logic                         tx_ready_q;
  logic [7:0]                   tx_type_q;
  logic [BYTES_W-1:0]           tx_bytes_q;
  logic [CHUNK_INDEX_SIZE-1:0]  tx_size_q;
  logic                         busy_q;
  logic [15:0]                  timeout_cnt_q;

  logic [CHANNEL_COUNT-1:0]     eligible;
  logic [2*CHANNEL_COUNT-1:0]   elig_dbl;
  logic [CHANNEL_COUNT-1:0]     elig_rot;
  logic                         grant_valid_d;
  logic [7:0]                   grant_d;
  logic [7:0]                   sel_type;
  logic [BYTES_W-1:0]           sel_bytes;
  logic [CHUNK_INDEX_SIZE-1:0]  sel_size;
  logic [CHANNEL_COUNT-1:0]     grant_onehot;

  assign eligible = channel_should_update & channel_enable;

  // Rotating the doubled mask by the pointer puts the search start at bit 0;
  // the descending loop leaves the lowest rotated offset as the winner.
  always_comb begin
    elig_dbl      = {eligible, eligible} >> ptr_q;
    elig_rot      = elig_dbl[CHANNEL_COUNT-1:0];
    grant_valid_d = 1'b0;
    grant_d       = '0;
    for (int k = CHANNEL_COUNT - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        grant_valid_d = 1'b1;
        grant_d       = wrap_index(ptr_q, k);
      end
    end
  end

  always_comb begin
    sel_type     = channel_chunk_type[int'(grant_q) * 8 +: 8];
    sel_bytes    = channel_chunk_bytes[int'(grant_q) * BYTES_W +: BYTES_W];
    sel_size     = clamp_size(channel_chunk_byte_size[int'(grant_q) * CHUNK_INDEX_SIZE +: CHUNK_INDEX_SIZE]);
    grant_onehot = CHANNEL_COUNT'(1) << grant_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      active_q      <= '0;
      wait_cnt_q    <= '0;
      chan_reset_q  <= '0;
      tx_ready_q    <= 1'b0;
      tx_type_q     <= '0;
      tx_bytes_q    <= '0;
      tx_size_q     <= '0;
      busy_q        <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_valid_d) begin
            grant_q  <= grant_d;
            active_q <= grant_d;
            busy_q   <= 1'b1;
            state_q  <= S_START;
          end
        end
        // Payload is captured once here so later request changes cannot disturb it.
        S_START: begin
          tx_type_q    <= sel_type;
          tx_bytes_q   <= sel_bytes;
          chan_reset_q <= grant_onehot;
          if (sel_size == '0) begin
            state_q <= S_NEXT;
          end else begin
            tx_ready_q <= 1'b1;
            tx_size_q  <= sel_size;
            state_q    <= S_STOP;
          end
        end
        S_STOP: begin
          tx_ready_q   <= 1'b0;
          tx_size_q    <= '0;
          chan_reset_q <= '0;
          wait_cnt_q   <= '0;
          state_q      <= S_WAIT;
        end
        // A done seen on the timeout cycle wins and is not counted as a timeout.
        S_WAIT: begin
          if (tx_is_chunker_done) begin
            state_q <= S_NEXT;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == TIMEOUT_LAST)) begin
            timeout_cnt_q <= sat_inc16(timeout_cnt_q);
            state_q       <= S_NEXT;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        S_NEXT: begin
          chan_reset_q <= '0;
          ptr_q        <= wrap_index(grant_q, 1);
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign channel_reset      = chan_reset_q;
  assign tx_is_chunk_ready  = tx_ready_q;
  assign tx_chunk_type      = tx_type_q;
  assign tx_chunk_bytes     = tx_bytes_q;
  assign tx_chunk_byte_size = tx_size_q;
  assign busy               = busy_q;
  assign active_channel     = active_q;
  assign timeout_count      = timeout_cnt_q;

endmodule

// File: tb/tb_min_os_tx_scheduler.sv
// Scoreboard bench for min_os_tx_scheduler: a round-robin reference model queues
// expected grants, a monitor pops them on each acknowledge, a chunker model replies.
module tb_min_os_tx_scheduler;

  localparam int N    = 4;
  localparam int MAXB = 8;
  localparam int CIS  = 32;
  localparam int TO   = 100;

  logic             CLK = 1'b0;
  logic             reset;
  logic [N-1:0]     channel_enable;
  logic [N-1:0]     channel_should_update;
  logic [8*N-1:0]   channel_chunk_type;
  logic [64*N-1:0]  channel_chunk_bytes;
  logic [CIS*N-1:0] channel_chunk_byte_size;
  logic [N-1:0]     channel_reset;
  logic             tx_is_chunk_ready;
  logic [7:0]       tx_chunk_type;
  logic [63:0]      tx_chunk_bytes;
  logic [CIS-1:0]   tx_chunk_byte_size;
  logic             tx_is_chunker_done;
  logic             busy;
  logic [7:0]       active_channel;
  logic [15:0]      timeout_count;

  logic done_c = 1'b0;
  logic done_late = 1'b0;
  assign tx_is_chunker_done = done_c | done_late;

  min_os_tx_scheduler #(
    .CHANNEL_COUNT(N), .MAX_CHUNK_BYTE_SIZE(MAXB),
    .CHUNK_INDEX_SIZE(CIS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .reset(reset),
    .channel_enable(channel_enable),
    .channel_should_update(channel_should_update),
    .channel_chunk_type(channel_chunk_type),
    .channel_chunk_bytes(channel_chunk_bytes),
    .channel_chunk_byte_size(channel_chunk_byte_size),
    .channel_reset(channel_reset),
    .tx_is_chunk_ready(tx_is_chunk_ready),
    .tx_chunk_type(tx_chunk_type),
    .tx_chunk_bytes(tx_chunk_bytes),
    .tx_chunk_byte_size(tx_chunk_byte_size),
    .tx_is_chunker_done(tx_is_chunker_done),
    .busy(busy),
    .active_channel(active_channel),
    .timeout_count(timeout_count)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    int          chan;
    logic [7:0]  typ;
    logic [63:0] bytes;
    logic [31:0] size;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          model_ptr = 0;
  int          exp_to = 0;
  bit          nodone = 1'b0;
  bit          rst_test = 1'b0;
  logic [7:0]  d_type[N];
  logic [63:0] d_bytes[N];
  logic [31:0] d_size[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic randomize_data();
    int r;
    for (int i = 0; i < N; i++) begin
      d_type[i]  = 8'($urandom_range(0, 255));
      d_bytes[i] = {$urandom, $urandom};
      r = int'($urandom_range(0, 9));
      if (r == 0)      d_size[i] = 32'd0;
      else if (r < 7)  d_size[i] = 32'($urandom_range(1, MAXB));
      else             d_size[i] = 32'($urandom_range(MAXB + 1, 40));
    end
  endtask

  task automatic pack_data();
    for (int i = 0; i < N; i++) begin
      channel_chunk_type[i*8 +: 8]            = d_type[i];
      channel_chunk_bytes[i*64 +: 64]         = d_bytes[i];
      channel_chunk_byte_size[i*CIS +: CIS]   = d_size[i];
    end
  endtask

  task automatic push_exp(input int c);
    exp_t e;
    e.chan  = c;
    e.typ   = d_type[c];
    e.bytes = d_bytes[c];
    e.size  = (d_size[c] > 32'(MAXB)) ? 32'(MAXB) : d_size[c];
    sb.push_back(e);
    if (nodone && e.size != 0) exp_to++;
  endtask

  // Expected grant order: eligible channels visited from the pointer upward, wrapping.
  task automatic run_phase(input logic [N-1:0] reqm, input logic [N-1:0] enm,
                           input bit nd, input bit hold);
    logic [N-1:0] elig;
    int           last;
    bit           any;
    bit           finished;
    nodone = nd;
    elig   = reqm & enm;
    pack_data();
    if (hold) begin
      for (int k = 0; k < 6; k++) push_exp((model_ptr + k) % N);
      model_ptr = (model_ptr + 6) % N;
    end else begin
      any  = 1'b0;
      last = 0;
      for (int k = 0; k < N; k++) begin
        if (elig[(model_ptr + k) % N]) begin
          push_exp((model_ptr + k) % N);
          last = (model_ptr + k) % N;
          any  = 1'b1;
        end
      end
      if (any) model_ptr = (last + 1) % N;
    end
    @(negedge CLK);
    channel_enable        = enm;
    channel_should_update = reqm;
    finished = 1'b0;
    for (int cyc = 0; cyc < 8000 && !finished; cyc++) begin
      @(negedge CLK);
      if (!hold) channel_should_update = channel_should_update & ~channel_reset;
      if (sb.size() == 0) begin
        if (hold) channel_should_update = '0;
        if (!busy) finished = 1'b1;
      end
    end
    chk("phase_complete", finished, 1);
    channel_should_update = '0;
    chk("timeout_count", timeout_count, exp_to);
    repeat (2) @(negedge CLK);
  endtask

  // Monitor: every acknowledge or strobe consumes one expected grant.
  always @(negedge CLK) begin : monitor
    exp_t       e;
    logic [N-1:0] oh;
    if (!reset) begin
      if (tx_is_chunk_ready || channel_reset != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: channel_reset=%b strobe=%b, nothing expected",
                   channel_reset, tx_is_chunk_ready);
        end else begin
          e  = sb.pop_front();
          oh = N'(1) << e.chan;
          chk("channel_reset", channel_reset, oh);
          chk("active_channel", active_channel, e.chan);
          chk("strobe", tx_is_chunk_ready, (e.size != 0));
          chk("chunk_type", tx_chunk_type, e.typ);
          chk("chunk_bytes", tx_chunk_bytes, e.bytes);
          chk("chunk_size", tx_chunk_byte_size, e.size);
        end
      end else begin
        chk("size_outside_strobe", tx_chunk_byte_size, 0);
      end
    end
  end

  // Chunker model: answers each strobe after a random delay, or stays silent.
  initial begin : chunker
    int n;
    forever begin
      @(negedge CLK);
      if (tx_is_chunk_ready) begin
        if (nodone) begin
          n = 0;
          for (int c = 1; c <= 300; c++) begin
            @(negedge CLK);
            if (!busy) begin
              n = c;
              break;
            end
          end
          if (!rst_test) chk("timeout_return_cycles", n, 102);
        end else begin
          repeat ($urandom_range(1, 40)) @(negedge CLK);
          done_c = 1'b1;
          @(negedge CLK);
          done_c = 1'b0;
          chk("busy_after_done_1", busy, 1);
          @(negedge CLK);
          chk("busy_after_done_2", busy, 0);
        end
      end
    end
  end

  initial begin : main
    bit seen;
    reset                   = 1'b1;
    channel_enable          = '0;
    channel_should_update   = '0;
    channel_chunk_type      = '0;
    channel_chunk_bytes     = '0;
    channel_chunk_byte_size = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_active", active_channel, 0);
    chk("rst_timeouts", timeout_count, 0);
    chk("rst_strobe", tx_is_chunk_ready, 0);
    chk("rst_chan_reset", channel_reset, 0);
    chk("rst_bytes", tx_chunk_bytes, 0);
    reset = 1'b0;
    @(negedge CLK);
    chk("idle_busy", busy, 0);

    randomize_data();
    for (int i = 0; i < N; i++) if (d_size[i] == 0) d_size[i] = 32'd3;
    run_phase(4'hF, 4'hF, 1'b0, 1'b1);
    randomize_data();
    run_phase(4'b1001, 4'hF, 1'b0, 1'b0);
    d_size[1] = 32'd0;
    run_phase(4'b0010, 4'hF, 1'b0, 1'b0);
    d_size[1] = 32'd20;
    run_phase(4'b0010, 4'hF, 1'b0, 1'b0);
    d_type[2]  = 8'd6;
    d_size[2]  = 32'd2;
    d_bytes[2] = 64'h0000_0000_0000_BEEF;
    run_phase(4'b0100, 4'hF, 1'b0, 1'b0);
    d_size[1] = 32'd5;
    run_phase(4'b0010, 4'hF, 1'b1, 1'b0);
    run_phase(4'b0010, 4'hF, 1'b0, 1'b0);
    run_phase(4'b0010, 4'b1101, 1'b0, 1'b0);

    for (int p = 0; p < 25; p++) begin
      randomize_data();
      run_phase(4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                ($urandom_range(0, 5) == 0), 1'b0);
    end

    // Leave the pointer at 1, then abandon a ch2 transfer mid-WAIT with reset.
    randomize_data();
    run_phase(4'b0001, 4'hF, 1'b0, 1'b0);
    rst_test  = 1'b1;
    nodone    = 1'b1;
    d_size[2] = 32'd3;
    pack_data();
    push_exp(2);
    @(negedge CLK);
    channel_enable        = 4'hF;
    channel_should_update = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (channel_reset[2]) begin
        seen = 1'b1;
        channel_should_update = '0;
      end
    end
    chk("rst_test_grant_seen", seen, 1);
    repeat (10) @(negedge CLK);
    chk("rst_test_in_wait", busy, 1);
    reset = 1'b1;
    @(negedge CLK);
    chk("midwait_busy", busy, 0);
    chk("midwait_active", active_channel, 0);
    chk("midwait_chan_reset", channel_reset, 0);
    chk("midwait_strobe", tx_is_chunk_ready, 0);
    chk("midwait_type", tx_chunk_type, 0);
    chk("midwait_bytes", tx_chunk_bytes, 0);
    chk("midwait_size", tx_chunk_byte_size, 0);
    reset     = 1'b0;
    done_late = 1'b1;
    @(negedge CLK);
    done_late = 1'b0;
    repeat (3) @(negedge CLK);
    chk("late_done_ignored", busy, 0);
    chk("sb_empty_after_reset", sb.size(), 0);
    model_ptr = 0;
    exp_to    = 0;
    rst_test  = 1'b0;
    nodone    = 1'b0;
    randomize_data();
    run_phase(4'b1001, 4'hF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
